// File: rtl/regfile_pkg.sv
// Shared types and default widths for the regfile writeback arbiter.
// Requester ids double as the age flag encoding (which slot holds the older write).
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback hold slot: captures {addr,data} on load, empties on grant.
// Writes to register 0 are swallowed here so they never reach arbitration.
module wb_hold_slot #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              grant,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              loaded
);

  logic              valid_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  // An accepted r0 request is a handshake only; the slot is left untouched.
  assign loaded = load & (load_addr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else if (loaded) begin
      valid_reg <= 1'b1;
      addr_reg  <= load_addr;
      data_reg  <= load_data;
    end else if (grant) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign addr  = addr_reg;
  assign data  = data_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (A) and load (M) writebacks:
// two hold slots, fixed priority to M with an A anti-starvation override, registered write port.
module regfile_wb_arbiter #(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] q_addr_s,
  input  logic [ADDR_W-1:0] q_addr_t,
  output logic              q_pend_s,
  output logic              q_pend_t,
  output logic [CNT_W-1:0]  wr_count
);

  import regfile_pkg::req_id_t;
  import regfile_pkg::REQ_A;
  import regfile_pkg::REQ_M;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic              a_slot_valid, m_slot_valid;
  logic [ADDR_W-1:0] a_slot_addr, m_slot_addr;
  logic [DATA_W-1:0] a_slot_data, m_slot_data;
  logic              a_loaded, m_loaded;
  logic              grant_a, grant_m;

  req_id_t           age_reg, age_next;
  logic [SW-1:0]     starve_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [CNT_W-1:0]  wr_count_reg;

  assign a_ready = ~a_slot_valid | grant_a;
  assign m_ready = ~m_slot_valid | grant_m;

  wb_hold_slot #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_slot_a (
    .clk      (clk),
    .reset    (reset),
    .load     (a_valid & a_ready),
    .load_addr(a_addr),
    .load_data(a_data),
    .grant    (grant_a),
    .valid    (a_slot_valid),
    .addr     (a_slot_addr),
    .data     (a_slot_data),
    .loaded   (a_loaded)
  );

  wb_hold_slot #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_slot_m (
    .clk      (clk),
    .reset    (reset),
    .load     (m_valid & m_ready),
    .load_addr(m_addr),
    .load_data(m_data),
    .grant    (grant_m),
    .valid    (m_slot_valid),
    .addr     (m_slot_addr),
    .data     (m_slot_data),
    .loaded   (m_loaded)
  );

  // Same-register writes must leave in program order; otherwise M wins unless A has starved.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (a_slot_valid && m_slot_valid) begin
      if (a_slot_addr == m_slot_addr) begin
        grant_a = (age_reg == REQ_A);
        grant_m = (age_reg == REQ_M);
      end else if (starve_reg == STARVE_LIM) begin
        grant_a = 1'b1;
      end else begin
        grant_m = 1'b1;
      end
    end else begin
      grant_a = a_slot_valid;
      grant_m = m_slot_valid;
    end
  end

  // The slot not loaded this edge is the older one; a simultaneous load makes M older.
  always_comb begin
    age_next = age_reg;
    if (a_loaded) begin
      age_next = REQ_M;
    end else if (m_loaded) begin
      age_next = REQ_A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_reg <= REQ_A;
    end else begin
      age_reg <= age_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg <= '0;
    end else if (a_slot_valid && !grant_a) begin
      if (starve_reg != STARVE_LIM) begin
        starve_reg <= starve_reg + 1'b1;
      end
    end else begin
      starve_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= grant_a | grant_m;
      if (grant_a) begin
        wr_addr_reg <= a_slot_addr;
        wr_data_reg <= a_slot_data;
      end else if (grant_m) begin
        wr_addr_reg <= m_slot_addr;
        wr_data_reg <= m_slot_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_reg <= '0;
    end else if ((grant_a || grant_m) && (wr_count_reg != {CNT_W{1'b1}})) begin
      wr_count_reg <= wr_count_reg + 1'b1;
    end
  end

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign wr_count = wr_count_reg;

  // Both decode queries share one compare structure.
  logic [ADDR_W-1:0] q_addr [2];
  logic [1:0]        q_pend;

  assign q_addr[0] = q_addr_s;
  assign q_addr[1] = q_addr_t;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      assign q_pend[gi] = (q_addr[gi] != '0) &
                          ((a_slot_valid & (a_slot_addr == q_addr[gi])) |
                           (m_slot_valid & (m_slot_addr == q_addr[gi])) |
                           (wr_en_reg    & (wr_addr_reg == q_addr[gi])));
    end
  endgenerate

  assign q_pend_s = q_pend[0];
  assign q_pend_t = q_pend[1];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a sequence-stamped behavioural model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int STARVE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_addr, m_addr;
  logic [31:0] a_data, m_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  q_addr_s, q_addr_t;
  logic        q_pend_s, q_pend_t;
  logic [15:0] wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .STARVE_MAX(STARVE),
    .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q_addr_s(q_addr_s), .q_addr_t(q_addr_t),
    .q_pend_s(q_pend_s), .q_pend_t(q_pend_t),
    .wr_count(wr_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Behavioural model: slot index 0 = A, 1 = M; age via global load sequence stamps.
  wb_req_t     slot_q   [2];
  bit          slot_v   [2];
  int          slot_seq [2];
  int          seq_ctr = 0;
  int          a_wait  = 0;
  bit          exp_wr_en = 0;
  logic [4:0]  exp_wr_addr = '0;
  logic [31:0] exp_wr_data = '0;
  int          exp_cnt = 0;
  bit          model_live = 0;
  logic [31:0] dut_rf [32];

  function automatic void model_grant(output bit ga, output bit gm);
    ga = 0;
    gm = 0;
    if (slot_v[0] && slot_v[1]) begin
      if (slot_q[0].addr == slot_q[1].addr) begin
        if (slot_seq[0] < slot_seq[1]) ga = 1;
        else gm = 1;
      end else if (a_wait >= STARVE) ga = 1;
      else gm = 1;
    end else begin
      ga = slot_v[0];
      gm = slot_v[1];
    end
  endfunction

  function automatic bit model_pend(input logic [4:0] q);
    return (q != 0) && ((slot_v[0] && slot_q[0].addr == q) ||
                        (slot_v[1] && slot_q[1].addr == q) ||
                        (exp_wr_en && exp_wr_addr == q));
  endfunction

  always @(posedge clk) begin : model_step
    bit ga, gm, ca, cm;
    if (reset) begin
      slot_v[0] = 0; slot_v[1] = 0;
      a_wait = 0; exp_wr_en = 0; exp_wr_addr = '0; exp_wr_data = '0; exp_cnt = 0;
      model_live = 1;
    end else begin
      model_grant(ga, gm);
      ca = a_valid && (!slot_v[0] || ga);
      cm = m_valid && (!slot_v[1] || gm);
      exp_wr_en = ga || gm;
      if (ga) begin exp_wr_addr = slot_q[0].addr; exp_wr_data = slot_q[0].data; end
      else if (gm) begin exp_wr_addr = slot_q[1].addr; exp_wr_data = slot_q[1].data; end
      if ((ga || gm) && exp_cnt < 65535) exp_cnt++;
      if (slot_v[0] && !ga) a_wait = (a_wait < STARVE) ? a_wait + 1 : a_wait;
      else a_wait = 0;
      if (ga) slot_v[0] = 0;
      if (gm) slot_v[1] = 0;
      if (cm && m_addr != 0) begin
        slot_v[1] = 1; slot_q[1] = '{addr: m_addr, data: m_data}; slot_seq[1] = seq_ctr++;
      end
      if (ca && a_addr != 0) begin
        slot_v[0] = 1; slot_q[0] = '{addr: a_addr, data: a_data}; slot_seq[0] = seq_ctr++;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ga, gm;
    if (model_live) begin
      model_grant(ga, gm);
      chk("a_ready",  a_ready,  !slot_v[0] || ga);
      chk("m_ready",  m_ready,  !slot_v[1] || gm);
      chk("wr_en",    wr_en,    exp_wr_en);
      chk("wr_addr",  wr_addr,  exp_wr_addr);
      chk("wr_data",  wr_data,  exp_wr_data);
      chk("wr_count", wr_count, exp_cnt);
      chk("q_pend_s", q_pend_s, model_pend(q_addr_s));
      chk("q_pend_t", q_pend_t, model_pend(q_addr_t));
    end
  end

  always @(negedge clk) if (wr_en) dut_rf[wr_addr] <= wr_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; a_valid = 1; a_addr = 5; a_data = 32'h1234;
    m_valid = 0; m_addr = 0; m_data = 0; q_addr_s = 0; q_addr_t = 0;

    // Reset holds everything idle even with a request present
    repeat (3) begin
      at_neg();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_count", wr_count, 0);
    end
    tick(); reset = 0; a_valid = 0;
    at_neg();

    // Lone A write r3 = 0x38
    tick(); a_valid = 1; a_addr = 3; a_data = 32'h38; q_addr_s = 3;
    at_neg(); chk("t2_a_ready", a_ready, 1); chk("t2_pend_pre", q_pend_s, 0);
    tick(); a_valid = 0;
    at_neg(); chk("t2_pend_slot", q_pend_s, 1); chk("t2_wr_en_k", wr_en, 0);
    tick();
    at_neg(); chk("t2_wr_en", wr_en, 1); chk("t2_wr_addr", wr_addr, 3);
    chk("t2_wr_data", wr_data, 32'h38); chk("t2_pend_out", q_pend_s, 1); chk("t2_count", wr_count, 1);
    tick();
    at_neg(); chk("t2_wr_en_off", wr_en, 0); chk("t2_pend_off", q_pend_s, 0);
    q_addr_s = 0;

    // Same-edge A r4 / M r7: M first
    tick(); a_valid = 1; a_addr = 4; a_data = 32'h44; m_valid = 1; m_addr = 7; m_data = 32'h77;
    at_neg(); chk("t3_a_ready", a_ready, 1); chk("t3_m_ready", m_ready, 1);
    tick(); a_valid = 0; m_valid = 0;
    at_neg(); chk("t3_a_wait", a_ready, 0); chk("t3_m_go", m_ready, 1);
    tick();
    at_neg(); chk("t3_first_addr", wr_addr, 7); chk("t3_first_data", wr_data, 32'h77);
    tick();
    at_neg(); chk("t3_second_addr", wr_addr, 4); chk("t3_second_en", wr_en, 1);
    chk("t3_count", wr_count, 3);

    // Same-edge A and M both to r9: M older, A's data is final
    tick(); a_valid = 1; a_addr = 9; a_data = 32'hAAAA0009; m_valid = 1; m_addr = 9; m_data = 32'h55550009;
    at_neg();
    tick(); a_valid = 0; m_valid = 0;
    at_neg(); chk("t4_a_ready", a_ready, 0); chk("t4_m_ready", m_ready, 1);
    tick();
    at_neg(); chk("t4_first_data", wr_data, 32'h55550009);
    tick();
    at_neg(); chk("t4_second_data", wr_data, 32'hAAAA0009); chk("t4_count", wr_count, 5);
    tick();
    at_neg(); chk("t4_r9_final", dut_rf[9], 32'hAAAA0009);

    // A to r9 one edge before M to r9: A first
    tick(); a_valid = 1; a_addr = 9; a_data = 32'h1;
    at_neg();
    tick(); a_valid = 0; m_valid = 1; m_addr = 9; m_data = 32'h2;
    at_neg(); chk("t4b_a_ready", a_ready, 1);
    tick(); m_valid = 0;
    at_neg(); chk("t4b_first_data", wr_data, 32'h1); chk("t4b_first_en", wr_en, 1);
    tick();
    at_neg(); chk("t4b_second_data", wr_data, 32'h2); chk("t4b_count", wr_count, 7);

    // Write to r0 is accepted and dropped
    tick(); a_valid = 1; a_addr = 0; a_data = 32'hFFFFFFE2;
    at_neg(); chk("t6_a_ready", a_ready, 1); chk("t6_pend", q_pend_s, 0);
    tick(); a_valid = 0;
    at_neg(); chk("t6_wr_en_1", wr_en, 0);
    tick();
    at_neg(); chk("t6_wr_en_2", wr_en, 0); chk("t6_count", wr_count, 7);

    // Starvation: A holding r2 while M streams distinct registers
    tick(); a_valid = 1; a_addr = 2; a_data = 32'h22; m_valid = 1; m_addr = 10; m_data = 32'h100;
    at_neg();
    for (int i = 1; i <= 12; i++) begin
      tick();
      a_valid = (i == 7);
      m_addr = 5'(10 + i); m_data = 32'h100 + i;
      at_neg();
      if (i <= 3) begin
        chk("t5_a_wait", a_ready, 0); chk("t5_m_win", m_ready, 1);
      end else if (i == 4) begin
        chk("t5_a_forced", a_ready, 1); chk("t5_m_held", m_ready, 0);
      end else if (i == 5) begin
        chk("t5_wr_addr", wr_addr, 2); chk("t5_wr_data", wr_data, 32'h22);
      end
    end
    tick(); a_valid = 0; m_valid = 0;
    repeat (4) tick();

    // Reset while both slots are full
    a_valid = 1; a_addr = 12; a_data = 32'hC; m_valid = 1; m_addr = 13; m_data = 32'hD;
    at_neg();
    tick(); a_valid = 0; m_valid = 0; reset = 1;
    at_neg();
    tick(); reset = 0;
    at_neg(); chk("t7_wr_en", wr_en, 0); chk("t7_count", wr_count, 0);
    chk("t7_a_ready", a_ready, 1); chk("t7_m_ready", m_ready, 1);
    repeat (3) begin
      tick();
      at_neg(); chk("t7_lost", wr_en, 0);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      reset    = ($urandom_range(0, 299) == 0);
      a_valid  = ($urandom_range(0, 99) < 55);
      a_addr   = 5'($urandom_range(0, 7));
      a_data   = $urandom;
      m_valid  = ($urandom_range(0, 99) < 65);
      m_addr   = 5'($urandom_range(0, 7));
      m_data   = $urandom;
      q_addr_s = 5'($urandom_range(0, 7));
      q_addr_t = 5'($urandom_range(0, 7));
    end
    tick(); a_valid = 0; m_valid = 0; reset = 0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
